// File: rtl/mem_port.sv
// Memory-side responder for the CPU bus: serves fetches, loads and stores by
// moving each 32-bit word as four little-endian byte accesses to an 8-bit SRAM.
module mem_port #(
    parameter int ADDR_W = 16,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        sysMode,
    input  logic              nextRead,
    input  logic              nextWrite,
    input  logic [31:0]       pc,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       cmdOut,
    output logic              cmdPush,
    output logic [31:0]       rdata,
    output logic              rdValid,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memWdata,
    input  logic [7:0]        memRdata,
    output logic              memOe,
    output logic              memWe
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, PUSH} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

    state_t      r_state;
    state_t      w_nextState;
    op_t         r_op;
    logic [3:0]  r_waitCnt;
    logic [1:0]  r_byteIdx;
    logic [23:0] r_word;
    logic [23:0] r_wdataHi;

    logic        w_fetchReq;
    logic        w_storeReq;
    logic        w_loadReq;
    logic        w_anyReq;
    logic        w_byteDone;
    logic        w_lastByte;
    logic [33:0] w_reqByteAddr;
    logic        w_unusedHighAddr;

    assign w_fetchReq    = (sysMode == 2'b10) && nextRead;
    assign w_storeReq    = (sysMode == 2'b01) && nextWrite;
    assign w_loadReq     = (sysMode == 2'b01) && nextRead && !nextWrite;
    assign w_anyReq      = w_fetchReq || w_storeReq || w_loadReq;
    assign w_byteDone    = (r_waitCnt == 4'(WAIT));
    assign w_lastByte    = w_byteDone && (r_byteIdx == 2'd3);
    assign w_reqByteAddr = {(w_fetchReq ? pc : addr), 2'b00};
    // Address bits above the SRAM width are discarded; the byte address wraps.
    assign w_unusedHighAddr = ^w_reqByteAddr[33:ADDR_W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ACCESS;
            ACCESS:  if (w_lastByte) w_nextState = DONE;
            DONE:    w_nextState = PUSH;
            PUSH:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_op      <= OP_FETCH;
            r_waitCnt <= 4'd0;
            r_byteIdx <= 2'd0;
            r_word    <= 24'd0;
            r_wdataHi <= 24'd0;
            cmdOut    <= 32'd0;
            rdata     <= 32'd0;
            cmdPush   <= 1'b0;
            rdValid   <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            memAddr   <= '0;
            memWdata  <= 8'd0;
            memOe     <= 1'b0;
            memWe     <= 1'b0;
        end else begin
            busy    <= (w_nextState != IDLE);
            cmdPush <= (w_nextState == PUSH) && (r_op == OP_FETCH);
            rdValid <= (w_nextState == PUSH) && (r_op == OP_LOAD);
            if ((r_state != IDLE) && w_anyReq) begin
                overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_op      <= w_storeReq ? OP_STORE : (w_fetchReq ? OP_FETCH : OP_LOAD);
                        memAddr   <= w_reqByteAddr[ADDR_W-1:0];
                        r_waitCnt <= 4'd0;
                        r_byteIdx <= 2'd0;
                        memOe     <= !w_storeReq;
                        memWe     <= w_storeReq;
                        memWdata  <= w_storeReq ? wdata[7:0] : 8'h00;
                        r_wdataHi <= wdata[31:8];
                    end
                end
                ACCESS: begin
                    if (w_byteDone) begin
                        // Bytes shift in from the top so byte 0 ends up lowest.
                        r_word    <= {memRdata, r_word[23:8]};
                        r_waitCnt <= 4'd0;
                        if (r_byteIdx == 2'd3) begin
                            memOe <= 1'b0;
                            memWe <= 1'b0;
                            if (r_op == OP_FETCH) begin
                                cmdOut <= {memRdata, r_word};
                            end else if (r_op == OP_LOAD) begin
                                rdata <= {memRdata, r_word};
                            end
                        end else begin
                            r_byteIdx <= r_byteIdx + 2'd1;
                            memAddr   <= memAddr + ADDR_W'(1);
                            memWdata  <= (r_op == OP_STORE) ? r_wdataHi[7:0] : 8'h00;
                            r_wdataHi <= {8'h00, r_wdataHi[23:8]};
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Randomized scoreboard bench for mem_port: a byte-array SRAM, a reference
// memory image, and monitors that check SRAM traffic and result strobes.
module tb_mem_port;

    localparam int ADDR_W = 16;
    localparam int WAIT   = 1;
    localparam int N      = 4 * (WAIT + 1);
    localparam int FETCH  = 0;
    localparam int LOAD   = 1;
    localparam int STORE  = 2;

    logic              clk;
    logic              nrst;
    logic [1:0]        sysMode;
    logic              nextRead;
    logic              nextWrite;
    logic [31:0]       pc;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       cmdOut;
    logic              cmdPush;
    logic [31:0]       rdata;
    logic              rdValid;
    logic              busy;
    logic              overrun;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memWdata;
    logic [7:0]        memRdata;
    logic              memOe;
    logic              memWe;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    resp_t       respQ[$];
    logic [15:0] rdAddrQ[$];
    logic [23:0] wrQ[$];

    logic [7:0]  sram   [0:65535];
    logic [7:0]  refMem [0:65535];
    logic [31:0] lastFetch;
    logic [31:0] lastLoad;
    int          cyc;
    int          checkCount;
    int          passCount;

    mem_port #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .clk(clk), .nrst(nrst), .sysMode(sysMode), .nextRead(nextRead),
        .nextWrite(nextWrite), .pc(pc), .addr(addr), .wdata(wdata),
        .cmdOut(cmdOut), .cmdPush(cmdPush), .rdata(rdata), .rdValid(rdValid),
        .busy(busy), .overrun(overrun), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memOe(memOe), .memWe(memWe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: asynchronous read, write on the clock edge.
    assign memRdata = sram[memAddr];
    always @(posedge clk) begin
        if (memWe) sram[memAddr] <= memWdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobe and every SRAM cycle is matched against the queues.
    always @(negedge clk) begin
        resp_t e;
        if (nrst) begin
            if (cmdPush || rdValid) begin
                if (respQ.size() == 0) begin
                    checkOutput("strobe_expected", 64'(respQ.size()), 64'd1);
                end else begin
                    e = respQ.pop_front();
                    checkOutput("strobe_kind", {62'd0, cmdPush, rdValid}, (e.kind == FETCH) ? 64'd2 : 64'd1);
                    checkOutput("strobe_data", (e.kind == FETCH) ? cmdOut : rdata, e.data);
                    checkOutput("strobe_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (memOe) begin
                if (rdAddrQ.size() == 0) checkOutput("read_expected", 64'(rdAddrQ.size()), 64'd1);
                else checkOutput("read_addr", memAddr, rdAddrQ.pop_front());
            end
            if (memWe) begin
                if (wrQ.size() == 0) checkOutput("write_expected", 64'(wrQ.size()), 64'd1);
                else checkOutput("write_byte", {memAddr, memWdata}, wrQ.pop_front());
            end
            if (memOe && memWe) checkOutput("oe_we_exclusive", 64'd1, 64'd0);
        end
    end

    // Issue one request and follow it to idle; intrude >= 0 raises a second
    // read request sampled at edge T0+intrude.
    task automatic applyStimulus(input int kind, input logic [31:0] a, input logic [31:0] d, input int intrude);
        logic [31:0] base;
        logic [15:0] ba;
        logic [31:0] word;
        resp_t       e;
        @(negedge clk);
        nextRead  = (kind != STORE) ? 1'b1 : 1'($urandom_range(0, 1));
        nextWrite = (kind == STORE);
        sysMode   = (kind == FETCH) ? 2'b10 : 2'b01;
        pc        = (kind == FETCH) ? a : $urandom;
        addr      = (kind == FETCH) ? $urandom : a;
        wdata     = d;
        base = a << 2;
        word = 32'd0;
        for (int k = 0; k < 4; k++) begin
            ba = 16'(base + 32'(k));
            for (int w = 0; w <= WAIT; w++) begin
                if (kind == STORE) wrQ.push_back({ba, d[8*k +: 8]});
                else rdAddrQ.push_back(ba);
            end
            if (kind == STORE) refMem[ba] = d[8*k +: 8];
            else word[8*k +: 8] = refMem[ba];
        end
        if (kind != STORE) begin
            e.kind = kind;
            e.data = word;
            e.cyc  = cyc + N + 2;
            respQ.push_back(e);
        end
        @(negedge clk);
        nextRead  = 1'b0;
        nextWrite = 1'b0;
        sysMode   = 2'($urandom);
        pc        = $urandom;
        addr      = $urandom;
        wdata     = $urandom;
        for (int c = 1; c <= N + 2; c++) begin
            if (c == intrude) begin
                sysMode  = 2'b10;
                nextRead = 1'b1;
            end
            @(negedge clk);
            nextRead = 1'b0;
            if (c == N) begin
                checkOutput("result_cmdOut", cmdOut, (kind == FETCH) ? word : lastFetch);
                checkOutput("result_rdata", rdata, (kind == LOAD) ? word : lastLoad);
            end
            if (c == N + 1) checkOutput("busy_before_idle", busy, 1'b1);
            if (c == N + 2) checkOutput("busy_idle", busy, 1'b0);
        end
        if (kind == FETCH) lastFetch = word;
        if (kind == LOAD) lastLoad = word;
    endtask

    task automatic applyIdle();
        @(negedge clk);
        sysMode   = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        nextRead  = 1'b1;
        nextWrite = 1'($urandom_range(0, 1));
        @(negedge clk);
        nextRead  = 1'b0;
        nextWrite = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_mode_busy", busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] ba0;
        int          kind;
        cyc        = 0;
        checkCount = 0;
        passCount  = 0;
        lastFetch  = 32'd0;
        lastLoad   = 32'd0;
        nrst       = 1'b0;
        sysMode    = 2'b00;
        nextRead   = 1'b0;
        nextWrite  = 1'b0;
        pc         = 32'd0;
        addr       = 32'd0;
        wdata      = 32'd0;
        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            sram[i]   = b;
            refMem[i] = b;
        end
        sram[16'h10] = 8'h02; refMem[16'h10] = 8'h02;
        sram[16'h11] = 8'h00; refMem[16'h11] = 8'h00;
        sram[16'h12] = 8'h90; refMem[16'h12] = 8'h90;
        sram[16'h13] = 8'hC9; refMem[16'h13] = 8'hC9;

        repeat (2) @(negedge clk);
        checkOutput("rst_cmdOut", cmdOut, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_flags", {cmdPush, rdValid, busy, overrun, memOe, memWe}, 6'd0);
        checkOutput("rst_memAddr", memAddr, 16'd0);
        checkOutput("rst_memWdata", memWdata, 8'd0);
        nrst = 1'b1;

        applyStimulus(FETCH, 32'd4, 32'd0, -1);
        checkOutput("plan_fetch_word", cmdOut, 32'hC9900002);

        applyIdle();
        applyIdle();
        checkOutput("idle_no_overrun", overrun, 1'b0);

        applyStimulus(STORE, 32'd8, 32'hDEADBEEF, -1);
        applyStimulus(LOAD, 32'd8, 32'd0, -1);
        checkOutput("plan_load_word", rdata, 32'hDEADBEEF);
        checkOutput("plan_load_keeps_cmdOut", cmdOut, 32'hC9900002);

        applyStimulus(FETCH, 32'h0000_3FFF, 32'd0, -1);
        applyStimulus(FETCH, 32'h0000_4000, 32'd0, -1);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
            d    = $urandom;
            applyStimulus(kind, a, d, -1);
            if ($urandom_range(0, 3) == 0) applyIdle();
        end
        checkOutput("no_overrun_yet", overrun, 1'b0);

        applyStimulus(FETCH, $urandom, 32'd0, 3);
        checkOutput("overrun_set", overrun, 1'b1);
        applyStimulus(LOAD, 32'd8, 32'd0, -1);
        checkOutput("overrun_sticky", overrun, 1'b1);

        // Store aborted by reset during cycle 3: only bytes 0 and 1 reach SRAM.
        a = $urandom_range(0, 15);
        d = $urandom;
        @(negedge clk);
        sysMode   = 2'b01;
        addr      = a;
        wdata     = d;
        nextWrite = 1'b1;
        nextRead  = 1'b0;
        ba0 = 16'(a << 2);
        wrQ.push_back({ba0, d[7:0]});
        wrQ.push_back({ba0, d[7:0]});
        wrQ.push_back({16'(ba0 + 16'd1), d[15:8]});
        refMem[ba0]            = d[7:0];
        refMem[16'(ba0 + 16'd1)] = d[15:8];
        @(negedge clk);
        nextWrite = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        checkOutput("abort_memWe", memWe, 1'b0);
        checkOutput("abort_flags", {busy, overrun, memOe, cmdPush, rdValid}, 5'd0);
        checkOutput("abort_cmdOut", cmdOut, 32'd0);
        checkOutput("abort_rdata", rdata, 32'd0);
        lastFetch = 32'd0;
        lastLoad  = 32'd0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_no_strobe_busy", busy, 1'b0);

        applyStimulus(FETCH, a, 32'd0, -1);
        applyStimulus(LOAD, a, 32'd0, -1);
        checkOutput("post_abort_overrun", overrun, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("resp_queue_empty", 64'(respQ.size()), 64'd0);
        checkOutput("read_queue_empty", 64'(rdAddrQ.size()), 64'd0);
        checkOutput("write_queue_empty", 64'(wrQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_port.md
# mem_port

Memory-side responder for the CPU bus. It serves instruction fetches and data load/store requests raised by the fetch/decode stage through `sysMode`, `nextRead` and `nextWrite`. Each 32-bit word is moved as four byte accesses to an external 8-bit SRAM with programmable wait states. Fetched instructions are returned on `cmdOut`/`cmdPush`, the command-buffer push interface of the fetch stage; load data is returned on `rdata`/`rdValid`.

## Interface
- `ADDR_W`, 16: width of the byte address `memAddr`.
- `WAIT`, 1: extra wait cycles per byte access (0..15).

- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `sysMode`  in  2  bus mode:
  - 2'b10 = instruction fetch.
  - 2'b01 = data access.
  - 2'b00 and 2'b11 = idle.
- `nextRead`  in  1  read request, single-cycle pulse.
- `nextWrite`  in  1  write request, single-cycle pulse.
- `pc`  in  32  word address for a fetch.
- `addr`  in  32  word address for a load or store.
- `wdata`  in  32  store data.
- `cmdOut`  out  32  fetched instruction word.
- `cmdPush`  out  1  push strobe; the fetch stage captures `cmdOut` on its rising edge.
- `rdata`  out  32  load data.
- `rdValid`  out  1  load-complete pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `overrun`  out  1  sticky protocol-error flag.
- `memAddr`  out  ADDR_W  SRAM byte address.
- `memWdata`  out  8  SRAM write byte.
- `memRdata`  in  8  SRAM read byte.
- `memOe`  out  1  SRAM output enable.
- `memWe`  out  1  SRAM write enable.

## Operation
- States: IDLE, ACCESS, DONE, PUSH.
- Request decode, sampled at a rising edge while in IDLE:
  - `sysMode`=10 and `nextRead` → FETCH; base address = `pc`.
  - `sysMode`=01 and `nextWrite` → STORE; base address = `addr`; `wdata` is latched. STORE wins if `nextRead` is also high.
  - `sysMode`=01 and `nextRead` (no `nextWrite`) → LOAD; base address = `addr`.
  - `sysMode`=00 or 11: all requests are ignored; `overrun` is not set.
- Base address is latched at acceptance. Later changes to `pc`, `addr` or `wdata` do not affect the transaction.
- ACCESS runs byte index k = 0..3; each byte takes WAIT+1 cycles.
  - `memAddr` = ((base << 2) + k) truncated to ADDR_W bits; wraps modulo 2^ADDR_W.
  - Read (FETCH/LOAD): `memOe`=1 for all cycles of the byte. `memRdata` is sampled at the edge ending the byte's last cycle.
  - Write (STORE): `memWe`=1 for all cycles of the byte. `memWdata` = wdata[8k+7:8k], stable for the whole byte.
  - Little-endian: byte k maps to bits [8k+7:8k].
- At the edge sampling byte 3, the assembled word loads into `cmdOut` (FETCH) or `rdata` (LOAD); the state goes to DONE.
  - STORE leaves `cmdOut` and `rdata` unchanged.
- DONE (1 cycle): `memOe`=`memWe`=0. The result is stable for one full cycle before any strobe.
- PUSH (1 cycle), then IDLE:
  - FETCH: `cmdPush`=1.
  - LOAD: `rdValid`=1.
  - STORE: no strobe.
- `cmdOut` and `rdata` hold their value until the next FETCH or LOAD completes.
- A request arriving while not in IDLE is dropped and sets `overrun`=1. `overrun` clears only on reset.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs.

## Timing
- Let T0 be the accepting edge and N = 4(WAIT+1).
- Cycle n is the interval after edge T0+n.
- Byte k occupies cycles k(WAIT+1) .. k(WAIT+1)+WAIT.
- Result registered at edge T0+N; DONE occupies cycle N.
- `cmdPush`/`rdValid` high in cycle N+1 only.
- `busy` is high in cycles 0..N+1.
- IDLE from edge T0+N+2; the next request can be accepted at edge T0+N+2.
- WAIT=1: result at T0+8, strobe in cycle 9, IDLE at T0+10.
- Reset values: state IDLE; `cmdOut`=0, `rdata`=0; `cmdPush`, `rdValid`, `busy`, `overrun`, `memOe`, `memWe` = 0; `memAddr`=0, `memWdata`=0.
- `nrst` low mid-transaction: all of the above take effect immediately (asynchronous).
  - `memWe` must drop without waiting for a clock edge.
  - The aborted transaction is never completed or strobed.

## Test plan
- FETCH, WAIT=1: SRAM[0x10..0x13] = 02,00,90,C9; `pc`=4; 10/`nextRead` pulse → `memAddr` 0x10..0x13; `cmdOut`=0xC9900002 at T0+8; `cmdPush` high in cycle 9 only; `busy` low from T0+10.
- STORE: 01/`nextWrite`, `addr`=8, `wdata`=0xDEADBEEF → bytes EF,BE,AD,DE written to 0x20..0x23 with `memWe` held two cycles each; no `cmdPush`/`rdValid`.
- LOAD of the same `addr`=8 → `rdata`=0xDEADBEEF; `rdValid` pulse in cycle 9; `cmdOut` unchanged. Then WAIT=0: strobe in cycle 5.
- Wrap, ADDR_W=16:
  - `pc`=0x3FFF → `memAddr` 0xFFFC..0xFFFF.
  - `pc`=0x4000 → `memAddr` 0x0000..0x0003.
- Overrun: second `nextRead` 3 cycles after the first → ignored; `overrun`=1; exactly one `cmdPush`; `sysMode`=00 with `nextRead` → no access and `overrun` stays 0.
- Reset abort: `nrst` low in cycle 3 of a STORE → `memWe`=0 with no clock edge; no strobe; `cmdOut`=0; a following FETCH completes normally.
